sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_arb_pick.sv | 28 ++
 rtl/sram_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Optional macro SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in place of round-robin.
package sram_arb_pkg;

    localparam int ADDR_BITS_DEF = 16;
    localparam int DATA_BITS_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Port index: 0 = fetch client, 1 = writeback client.
    typedef logic port_t;

    localparam port_t PORT_FETCH = 1'b0;
    localparam port_t PORT_WB    = 1'b1;

    function automatic logic [1:0] port_onehot(input port_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for the SRAM arbiter.
// With SRAM_ARB_FIXED_PRIO_EN defined, port 0 always wins and no priority input exists.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  port_t      prio,
`endif
    output logic       valid,
    output port_t      winner
);

    always_comb begin
        valid  = |req;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        winner = req[0] ? PORT_FETCH : PORT_WB;
`else
        // A lone requester wins outright; only a tie consults the priority bit.
        if (req == 2'b11) begin
            winner = prio;
        end else begin
            winner = req[1] ? PORT_WB : PORT_FETCH;
        end
`endif
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-ported SRAM: IDLE -> ACCESS -> DONE per transaction.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF,
    parameter int ACCESS_CYCLES = 2
)
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic [1:0]             req,
    input  logic [1:0]             write,
    input  logic [2*ADDR_BITS-1:0] req_address,
    input  logic [2*DATA_BITS-1:0] req_w_data,
    output logic [1:0]             grant,
    output logic [1:0]             done,
    output logic [DATA_BITS-1:0]   done_r_data,
    output logic                   busy,
    output logic [ADDR_BITS-1:0]   address,
    output logic [DATA_BITS-1:0]   w_data,
    input  logic [DATA_BITS-1:0]   r_data,
    output logic                   read_enable,
    output logic                   write_enable,
    output logic [1:0]             state
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] ACCESS = ST_ACCESS;
    localparam logic [1:0] DONE   = ST_DONE;
    localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);

    logic [3:0] count;
    port_t      owner;
    logic       op_write;
    logic       pick_valid;
    port_t      winner;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    port_t      prio;
`endif

    sram_arb_pick u_pick (
        .req    (req),
`ifndef SRAM_ARB_FIXED_PRIO_EN
        .prio   (prio),
`endif
        .valid  (pick_valid),
        .winner (winner)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            count        <= 4'd0;
            owner        <= PORT_FETCH;
            op_write     <= 1'b0;
            grant        <= 2'b00;
            done         <= 2'b00;
            done_r_data  <= '0;
            address      <= '0;
            w_data       <= '0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            prio         <= PORT_FETCH;
`endif
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (enable && pick_valid) begin
                        state        <= ACCESS;
                        owner        <= winner;
                        op_write     <= write[winner];
                        address      <= winner ? req_address[2*ADDR_BITS-1:ADDR_BITS]
                                               : req_address[ADDR_BITS-1:0];
                        w_data       <= winner ? req_w_data[2*DATA_BITS-1:DATA_BITS]
                                               : req_w_data[DATA_BITS-1:0];
                        grant        <= port_onehot(winner);
                        count        <= 4'd0;
                        // Strobes are registered so they appear in the first ACCESS cycle.
                        read_enable  <= ~write[winner];
                        write_enable <= write[winner];
                    end
                end
                ACCESS: begin
                    count <= count + 4'd1;
                    if (count == LAST) begin
                        if (!op_write) begin
                            done_r_data <= r_data;
                        end
                        read_enable  <= 1'b0;
                        write_enable <= 1'b0;
                        grant        <= 2'b00;
                        done         <= port_onehot(owner);
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // Address and write data stay put; only control returns to idle.
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    prio  <= ~owner;
`endif
                    count <= 4'd0;
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    read_enable  <= 1'b0;
                    write_enable <= 1'b0;
                    grant        <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural SRAM model and per-cycle protocol monitor.
// Honours SRAM_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_sram_arbiter;

    localparam int AB = 16;
    localparam int DB = 24;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          enable;
    logic [1:0]    req;
    logic [1:0]    write;
    logic [2*AB-1:0] req_address;
    logic [2*DB-1:0] req_w_data;
    logic [1:0]    grant;
    logic [1:0]    done;
    logic [DB-1:0] done_r_data;
    logic          busy;
    logic [AB-1:0] address;
    logic [DB-1:0] w_data;
    logic [DB-1:0] r_data;
    logic          read_enable;
    logic          write_enable;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    logic [DB-1:0] mem [0:65535];
    logic [1:0]    prev_done = 2'b00;

    sram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .ACCESS_CYCLES(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .req          (req),
        .write        (write),
        .req_address  (req_address),
        .req_w_data   (req_w_data),
        .grant        (grant),
        .done         (done),
        .done_r_data  (done_r_data),
        .busy         (busy),
        .address      (address),
        .w_data       (w_data),
        .r_data       (r_data),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .state        (state)
    );

    // Clock and SRAM model
    always #5 clk = ~clk;

    assign r_data = mem[address];

    always @(posedge clk) begin
        if (write_enable) mem[address] <= w_data;
    end

    // Protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        checks++;
        if ($countones(grant) > 1) begin
            errors++; $display("FAIL mon_grant_onehot: grant=%b", grant);
        end
        if (read_enable && write_enable) begin
            errors++; $display("FAIL mon_both_strobes: re=%b we=%b", read_enable, write_enable);
        end
        if ((read_enable || write_enable) && (state != 2'd1)) begin
            errors++; $display("FAIL mon_strobe_state: state=%0d required ACCESS", state);
        end
        if ($countones(done) > 1 || (done & prev_done) != 2'b00) begin
            errors++; $display("FAIL mon_done_pulse: done=%b prev=%b", done, prev_done);
        end
        prev_done = done;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic wr, input logic [AB-1:0] a, input logic [DB-1:0] d);
        write[p] = wr;
        req_address[p*AB +: AB] = a;
        req_w_data[p*DB +: DB] = d;
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    // Tests
    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (read_enable !== 1'b0 || write_enable !== 1'b0) begin errors++; $display("FAIL reset_strobes: re=%b we=%b want 0 0", read_enable, write_enable); end
        checks++; if (address !== 16'h0000 || w_data !== 24'h000000) begin errors++; $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", address, w_data); end
        checks++; if (done_r_data !== 24'h000000) begin errors++; $display("FAIL reset_rdata: got %h want 0", done_r_data); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        mem[16'h0014] = 24'h3A5C7E;
        set_port(0, 1'b0, 16'h0014, 24'h000000);
        req = 2'b01;
        tick();
        checks++; if (read_enable !== 1'b1 || write_enable !== 1'b0) begin errors++; $display("FAIL read_c1_strobes: re=%b we=%b want 1 0", read_enable, write_enable); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL read_c1_grant: got %b want 01", grant); end
        checks++; if (address !== 16'h0014) begin errors++; $display("FAIL read_c1_addr: got %h want 0014", address); end
        tick();
        checks++; if (read_enable !== 1'b1 || done !== 2'b00) begin errors++; $display("FAIL read_c2: re=%b done=%b want 1 00", read_enable, done); end
        tick();
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL read_c3_done: got %b want 01", done); end
        checks++; if (read_enable !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL read_c3_turn: re=%b grant=%b want 0 00", read_enable, grant); end
        checks++; if (done_r_data !== 24'h3A5C7E) begin errors++; $display("FAIL read_c3_data: got %h want 3a5c7e", done_r_data); end
        checks++; if (address !== 16'h0014) begin errors++; $display("FAIL read_c3_addr_hold: got %h want 0014", address); end
        req = 2'b00;
        tick();
        checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL read_c4_idle: done=%b busy=%b want 00 0", done, busy); end
    endtask

    task automatic test_single_write();
        mem[16'h0000] = 24'h123456;
        set_port(1, 1'b1, 16'h0000, 24'h0000BB);
        req = 2'b10;
        tick();
        checks++; if (write_enable !== 1'b1 || read_enable !== 1'b0) begin errors++; $display("FAIL write_c1_strobes: re=%b we=%b want 0 1", read_enable, write_enable); end
        checks++; if (address !== 16'h0000 || w_data !== 24'h0000BB) begin errors++; $display("FAIL write_c1_bus: addr=%h wdata=%h want 0000 0000bb", address, w_data); end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL write_c1_grant: got %b want 10", grant); end
        tick();
        checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL write_c2_we: got %b want 1", write_enable); end
        tick();
        checks++; if (done !== 2'b10 || write_enable !== 1'b0) begin errors++; $display("FAIL write_c3: done=%b we=%b want 10 0", done, write_enable); end
        checks++; if (w_data !== 24'h0000BB) begin errors++; $display("FAIL write_c3_wdata_hold: got %h want 0000bb", w_data); end
        req = 2'b00;
        tick();
        set_port(0, 1'b0, 16'h0000, 24'h000000);
        req = 2'b01;
        tick();
        tick();
        tick();
        checks++; if (done !== 2'b01 || done_r_data !== 24'h0000BB) begin errors++; $display("FAIL write_readback: done=%b data=%h want 01 0000bb", done, done_r_data); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        pulse_reset();
        set_port(0, 1'b0, 16'h0100, 24'h000000);
        set_port(1, 1'b0, 16'h0200, 24'h000000);
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            tick();
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL contention_grant_%0d: got %b want %b", i, grant, exp_g); end
            tick();
            tick();
            checks++; if (done !== exp_g) begin errors++; $display("FAIL contention_done_%0d: got %b want %b", i, done, exp_g); end
            tick();
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_enable_drop();
        logic [1:0] exp_g;
        pulse_reset();
        set_port(0, 1'b0, 16'h0014, 24'h000000);
        set_port(1, 1'b0, 16'h0000, 24'h000000);
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL en_drop_grant: got %b want 01", grant); end
        enable = 1'b0;
        req = 2'b11;
        tick();
        tick();
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL en_drop_done: got %b want 01", done); end
        tick();
        tick();
        tick();
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL en_drop_hold: grant=%b busy=%b want 00 0", grant, busy); end
        enable = 1'b1;
        tick();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        checks++; if (grant !== exp_g) begin errors++; $display("FAIL en_resume_grant: got %b want %b", grant, exp_g); end
        tick();
        tick();
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_access();
        bit saw_done;
        set_port(0, 1'b0, 16'h0014, 24'h000000);
        set_port(1, 1'b1, 16'h0300, 24'h00ABCD);
        req = 2'b01;
        tick();
        checks++; if (read_enable !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: re=%b want 1", read_enable); end
        n_rst = 1'b0;
        tick();
        checks++; if (read_enable !== 1'b0 || write_enable !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rst_mid_abort: re=%b we=%b grant=%b want 0 0 00", read_enable, write_enable, grant); end
        checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone: done=%b busy=%b want 00 0", done, busy); end
        n_rst = 1'b1;
        req = 2'b10;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rst_mid_port1: got %b want 10", grant); end
        tick();
        tick();
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL rst_mid_port1_done: got %b want 10", done); end
        req = 2'b00;
        tick();
        checks++; if (mem[16'h0300] !== 24'h00ABCD) begin errors++; $display("FAIL rst_mid_mem: got %h want 00abcd", mem[16'h0300]); end
        // Both pending straight after reset: reset priority belongs to port 0.
        pulse_reset();
        req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_both_grant: got %b want 01", grant); end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done == 2'b01) saw_done = 1'b1;
        end
        req = 2'b00;
        checks++; if (saw_done !== 1'b1) begin errors++; $display("FAIL rst_both_done: saw_done=%b want 1", saw_done); end
        tick();
        tick();
    endtask

    initial begin
        n_rst = 1'b0;
        enable = 1'b1;
        req = 2'b00;
        write = 2'b00;
        req_address = '0;
        req_w_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 24'(i * 3);
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_enable_drop();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
